// File: rtl/axil_slave_regfile.sv
// AXI4-Lite slave register file: DEPTH words of DATA_WIDTH bits with byte-strobed writes.
// Latency: BVALID two cycles after both AW and W have been accepted; RVALID one cycle after AR.
// Backpressure: AW and W are each held in one register, and their READY stays low until the commit. B and R hold until their handshake.
//
// Ports:
//   ACLK, ARESETN                       clock and synchronous active-low reset
//   AWADDR/AWVALID/AWREADY              write address channel
//   WDATA/WSTRB/WVALID/WREADY           write data channel with byte enables
//   BRESP/BVALID/BREADY                 write response channel
//   ARADDR/ARVALID/ARREADY              read address channel
//   RDATA/RRESP/RVALID/RREADY           read data channel
//
// Optional feature: define AXIL_SLVERR_RESP_EN to answer word indices >= DEPTH with SLVERR.
// When it is not defined, the word index wraps modulo DEPTH and every response is OKAY.
module axil_slave_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RVALID,
    input  logic                    RREADY
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_WIDTH - LSB;
    localparam int MEM_AW = $clog2(DEPTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

    // Storage
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Write side state
    logic                  r_awready;
    logic                  r_wready;
    logic                  r_aw_held;
    logic                  r_w_held;
    logic [IDX_W-1:0]      r_aw_idx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]     r_wstrb;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;

    // Read side state
    rstate_t               r_rstate;
    logic                  r_arready;
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;

    logic [IDX_W-1:0]      w_aw_idx;
    logic [IDX_W-1:0]      w_ar_idx;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_commit;
    logic                  w_wr_oor;
    logic                  w_rd_oor;
    logic                  w_unused;

    assign w_aw_idx = AWADDR[ADDR_WIDTH-1:LSB];
    assign w_ar_idx = ARADDR[ADDR_WIDTH-1:LSB];

    assign w_aw_hs  = AWVALID && r_awready;
    assign w_w_hs   = WVALID && r_wready;
    // A commit waits for any earlier response to be taken, so BRESP is never overwritten.
    assign w_commit = r_aw_held && r_w_held && !r_bvalid;

`ifdef AXIL_SLVERR_RESP_EN
    assign w_wr_oor = (32'(r_aw_idx) >= DEPTH);
    assign w_rd_oor = (32'(w_ar_idx) >= DEPTH);
`else
    // The low index bits select the word, so the address space aliases onto the memory.
    assign w_wr_oor = 1'b0;
    assign w_rd_oor = 1'b0;
`endif

    // The byte-offset bits and any index bits above the memory size are not used to select a word.
    assign w_unused = ^{AWADDR[LSB-1:0], ARADDR[LSB-1:0], r_aw_idx, w_ar_idx};

    // Write channels and memory update
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_idx  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit) begin
            // Both holding registers are full, so neither READY is high and no handshake can occur on this edge.
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_wr_oor ? RESP_SLVERR : RESP_OKAY;
            if (!w_wr_oor) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (r_wstrb[b]) begin
                        r_mem[r_aw_idx[MEM_AW-1:0]][8*b +: 8] <= r_wdata[8*b +: 8];
                    end
                end
            end
        end else begin
            if (w_aw_hs) begin
                r_aw_idx  <= w_aw_idx;
                r_aw_held <= 1'b1;
                r_awready <= 1'b0;
            end else if (!r_aw_held) begin
                // AWREADY first rises here, in the cycle after reset is released.
                r_awready <= 1'b1;
            end

            if (w_w_hs) begin
                r_wdata  <= WDATA;
                r_wstrb  <= WSTRB;
                r_w_held <= 1'b1;
                r_wready <= 1'b0;
            end else if (!r_w_held) begin
                r_wready <= 1'b1;
            end

            if (r_bvalid && BREADY) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Read channel FSM
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (r_arready && ARVALID) begin
                        r_rstate  <= R_DATA;
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        // Nonblocking semantics give the pre-commit value when a write lands on the same edge.
                        r_rdata   <= w_rd_oor ? '0 : r_mem[w_ar_idx[MEM_AW-1:0]];
                        r_rresp   <= w_rd_oor ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (RREADY) begin
                        r_rstate  <= R_IDLE;
                        r_arready <= 1'b1;
                        r_rvalid  <= 1'b0;
                        r_rdata   <= '0;
                        r_rresp   <= RESP_OKAY;
                    end
                end
                default: begin
                    r_rstate  <= R_IDLE;
                    r_arready <= 1'b0;
                    r_rvalid  <= 1'b0;
                end
            endcase
        end
    end

    assign AWREADY = r_awready;
    assign WREADY  = r_wready;
    assign BVALID  = r_bvalid;
    assign BRESP   = r_bresp;
    assign ARREADY = r_arready;
    assign RVALID  = r_rvalid;
    assign RDATA   = r_rdata;
    assign RRESP   = r_rresp;

endmodule

// File: doc/axil_slave_regfile.md
AXIL_SLAVE_REGFILE -- requirements
Module: axil_slave_regfile

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width in bits (32 or 64).
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, byte-address width.
REQ-003 SHALL have parameter DEPTH, default 32, word count; power of two, at most 2^(ADDR_WIDTH-LSB), where LSB = log2(DATA_WIDTH/8).
REQ-004 SHALL have ports: ACLK in 1 clock; ARESETN in 1 reset; one clock; reset is synchronous and active-low.
REQ-005 SHALL have AWADDR in ADDR_WIDTH; AWVALID in 1; AWREADY out 1 -- write address channel.
REQ-006 SHALL have WDATA in DATA_WIDTH; WSTRB in DATA_WIDTH/8 byte enables; WVALID in 1; WREADY out 1.
REQ-007 SHALL have BRESP out 2; BVALID out 1; BREADY in 1 -- write response channel.
REQ-008 SHALL have ARADDR in ADDR_WIDTH; ARVALID in 1; ARREADY out 1 -- read address channel.
REQ-009 SHALL have RDATA out DATA_WIDTH; RRESP out 2; RVALID out 1; RREADY in 1 -- read data channel.

Function
REQ-010 SHALL compute word index = addr[ADDR_WIDTH-1:LSB] and ignore addr[LSB-1:0].
REQ-011 SHALL hold every ready/valid/data/resp output in a register; a handshake occurs at a rising edge when VALID and READY are both 1.
REQ-012 SHALL accept AW and W independently in any order: per channel, a holding register plus a held flag; READY drops the cycle after its handshake and stays low until commit.
REQ-013 SHALL commit at the edge where both held flags are 1 and BVALID is 0: update bytes with WSTRB[i]=1, leave other bytes unchanged, clear both flags, reassert AWREADY/WREADY, set BVALID=1 with BRESP.
REQ-014 SHALL latency: handshakes of both AW and W complete by cycle N, BVALID=1 in cycle N+2.
REQ-015 SHALL hold BVALID and BRESP stable until the B handshake; BVALID=0 on the edge after it.
REQ-016 SHALL allow a new AW/W to be accepted while BVALID=1; its commit waits until BVALID=0.
REQ-017 SHALL read FSM states R_IDLE (ARREADY=1, RVALID=0) and R_DATA (ARREADY=0, RVALID=1); on AR handshake go to R_DATA with RDATA=mem[index] in the next cycle; on R handshake go to R_IDLE with RDATA=0, RRESP=0.
REQ-018 SHALL hold RDATA/RRESP stable while RVALID=1 and RREADY=0.
REQ-019 SHALL return the pre-write value in RDATA when a commit and an AR handshake to the same word occur on the same edge.
REQ-020 SHALL run read and write channels fully concurrently with no mutual stall.
REQ-021 SHALL treat WSTRB=0 as a legal write: no memory change, BRESP=OKAY (2'b00).

Reset
REQ-022 SHALL, while ARESETN=0 at a rising ACLK edge: AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, held flags cleared, all DEPTH words set to 0.
REQ-023 SHALL assert AWREADY, WREADY, ARREADY in the first cycle after ARESETN returns to 1.
REQ-024 SHALL abandon any held AW/W, pending B or pending R when reset is applied mid-transaction; no memory write occurs from abandoned data.

Configuration
REQ-025 SHALL, with macro AXIL_SLVERR_RESP_EN defined, treat index >= DEPTH as out of range: writes suppressed with BRESP=SLVERR (2'b10); reads return RDATA=0 with RRESP=SLVERR.
REQ-026 SHALL, without AXIL_SLVERR_RESP_EN, use index modulo DEPTH (low bits); all responses are OKAY.

Verification
REQ-027 SHALL check: AW=0x08 and W=0xDEADBEEF, WSTRB=0xF in the same cycle, BREADY=1 -> BVALID two cycles later, BRESP=00; then AR=0x08 -> RDATA=0xDEADBEEF, RRESP=00, one cycle after the AR handshake.
REQ-028 SHALL check: W=0x11223344 three cycles before AW=0x0C -> no commit until AW is accepted; AW and W held; readback 0x11223344.
REQ-029 SHALL check: word 0x04 = 0xAABBCCDD, then write 0x00000000 with WSTRB=0x5 -> readback 0xAA00CC00.
REQ-030 SHALL check: BREADY=0 for 5 cycles -> BVALID and BRESP stable; a second AW/W is accepted, and its commit follows the B handshake.
REQ-031 SHALL check: defaults, AR=0x80 (index 32) -> with macro, RRESP=10 and RDATA=0; without macro, RDATA=mem[0], RRESP=00.
REQ-032 SHALL check: ARESETN=0 while RVALID=1 and AW is held -> next cycle all outputs 0, memory reads 0, no stray write.
